// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding / hazard controller:
// operand-mux select codes and the default register-address width.
package fwd_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    // EX operand mux select codes; the nearer producer has the higher code
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Per-operand forwarding priority compare: picks the nearest in-flight
// producer (EX, then MEM) of the source register, else the register file.
module fwd_sel_cmp
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = fwd_hazard_ctrl_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rw,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rw,
    output logic [1:0]        sel
);

    // nearer producer wins; x0 and unused operands never forward
    always_comb begin
        sel = FWD_RF;
        if (use_rs && (rs != '0)) begin
            if (ex_rw && (ex_rd == rs)) begin
                sel = FWD_EXMEM;
            end else if (mem_rw && (mem_rd == rs)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destination registers of EX/MEM/WB, registers the EX operand
// forwarding selects and raises a one-cycle stall on load-use.
// Optional feature macro: FWD_PERF_CNT_EN adds stall / forward counters.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = fwd_hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic              stall_o,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel
`ifdef FWD_PERF_CNT_EN
   ,output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_rw, ex_mr, mem_rw, wb_rw;
    logic              haz, rs1_hit, rs2_hit, bubble;
    logic [1:0]        cmp_a, cmp_b;

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_a (
        .rs     (id_rs1),
        .use_rs (id_use_rs1),
        .ex_rd  (ex_rd),
        .ex_rw  (ex_rw),
        .mem_rd (mem_rd),
        .mem_rw (mem_rw),
        .sel    (cmp_a)
    );

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_b (
        .rs     (id_rs2),
        .use_rs (id_use_rs2),
        .ex_rd  (ex_rd),
        .ex_rw  (ex_rw),
        .mem_rd (mem_rd),
        .mem_rw (mem_rw),
        .sel    (cmp_b)
    );

    // load in EX whose result the ID instruction needs next cycle
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
        haz     = ex_mr && ex_rw && (rs1_hit || rs2_hit) && id_valid;
        stall_o = haz && !flush_i;
        bubble  = flush_i || stall_o || !id_valid;
    end

    // stage tracking and registered selects; hold freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd        <= '0;
            ex_rw        <= 1'b0;
            ex_mr        <= 1'b0;
            mem_rd       <= '0;
            mem_rw       <= 1'b0;
            wb_rd        <= '0;
            wb_rw        <= 1'b0;
            ex_fwd_a_sel <= FWD_RF;
            ex_fwd_b_sel <= FWD_RF;
        end else if (!hold_i) begin
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            wb_rd  <= mem_rd;
            wb_rw  <= mem_rw;
            if (bubble) begin
                ex_rd        <= '0;
                ex_rw        <= 1'b0;
                ex_mr        <= 1'b0;
                ex_fwd_a_sel <= FWD_RF;
                ex_fwd_b_sel <= FWD_RF;
            end else begin
                ex_rd        <= id_rd;
                ex_rw        <= id_regwrite && (id_rd != '0);
                ex_mr        <= id_memread;
                ex_fwd_a_sel <= cmp_a;
                ex_fwd_b_sel <= cmp_b;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    // free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (!hold_i) begin
            if (stall_o) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (!bubble && ((cmp_a != FWD_RF) || (cmp_b != FWD_RF))) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios
// followed by randomized traffic, all checked against an in-flight
// instruction model.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold_i, flush_i, id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic          stall_o;
    logic [1:0]    ex_fwd_a_sel, ex_fwd_b_sel;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt, perf_fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .stall_o      (stall_o),
        .ex_fwd_a_sel (ex_fwd_a_sel),
        .ex_fwd_b_sel (ex_fwd_b_sel)
`ifdef FWD_PERF_CNT_EN
       ,.perf_stall_cnt(perf_stall_cnt),
        .perf_fwd_cnt  (perf_fwd_cnt)
`endif
    );

    // model: instructions in flight, index = distance past ID (0=EX,1=MEM,2=WB)
    typedef struct {
        bit writes;
        bit is_load;
        int rd;
    } instr_t;

    instr_t      pipe[3];
    logic [1:0]  m_sel_a, m_sel_b;
    int unsigned m_stalls, m_fwds;

    function automatic instr_t no_instr();
        instr_t n;
        n.writes  = 1'b0;
        n.is_load = 1'b0;
        n.rd      = 0;
        return n;
    endfunction

    // nearest older instruction writing rs: distance 0 -> EX/MEM, 1 -> MEM/WB
    function automatic logic [1:0] m_fwd(int rs, bit used);
        if (!used || rs == 0) return 2'b00;
        for (int d = 0; d < 2; d++)
            if (pipe[d].writes && pipe[d].rd == rs)
                return (d == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        bit needs;
        needs = (id_use_rs1 && int'(id_rs1) == pipe[0].rd) ||
                (id_use_rs2 && int'(id_rs2) == pipe[0].rd);
        return id_valid && pipe[0].is_load && pipe[0].writes && needs && !flush_i;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = no_instr();
        m_sel_a  = 2'b00;
        m_sel_b  = 2'b00;
        m_stalls = 0;
        m_fwds   = 0;
    endtask

    task automatic m_edge();
        instr_t     nx;
        logic [1:0] na, nb;
        bit         st;
        if (hold_i) return;
        st = m_stall();
        nx = no_instr();
        na = 2'b00;
        nb = 2'b00;
        if (st) m_stalls++;
        if (!flush_i && !st && id_valid) begin
            nx.writes  = id_regwrite && (id_rd != 0);
            nx.is_load = id_memread;
            nx.rd      = int'(id_rd);
            na = m_fwd(int'(id_rs1), id_use_rs1);
            nb = m_fwd(int'(id_rs2), id_use_rs2);
            if (na != 0 || nb != 0) m_fwds++;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        m_sel_a = na;
        m_sel_b = nb;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit hold, input bit flush);
        id_valid    = v;
        id_rs1      = AW'(rs1);
        id_use_rs1  = u1;
        id_rs2      = AW'(rs2);
        id_use_rs2  = u2;
        id_rd       = AW'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        hold_i      = hold;
        flush_i     = flush;
    endtask

    logic last_stall;

    // one pipeline cycle: stall checked before the edge, selects after it
    task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit hold, input bit flush);
        drive(v, rs1, u1, rs2, u2, rd, rw, mr, hold, flush);
        #1;
        chk("stall_o", {31'd0, stall_o}, {31'd0, m_stall()});
        last_stall = stall_o;
        m_edge();
        @(posedge clk);
        #1;
        chk("sel_a", {30'd0, ex_fwd_a_sel}, {30'd0, m_sel_a});
        chk("sel_b", {30'd0, ex_fwd_b_sel}, {30'd0, m_sel_b});
`ifdef FWD_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stalls);
        chk("perf_fwd", perf_fwd_cnt, m_fwds);
`endif
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_sel_a", {30'd0, ex_fwd_a_sel}, 32'd0);
        chk("rst_sel_b", {30'd0, ex_fwd_b_sel}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef FWD_PERF_CNT_EN
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_fwd", perf_fwd_cnt, 32'd0);
`endif

        // add x5 ; sub x6,x5,x1
        step(1, 2, 1, 3, 1, 5, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("t1_nostall", {31'd0, last_stall}, 32'd0);
        chk("t1_sel_a", {30'd0, ex_fwd_a_sel}, 32'd2);
        chk("t1_sel_b", {30'd0, ex_fwd_b_sel}, 32'd0);

        // producer x7 ; unrelated ; consumer of x7 on rs2
        step(1, 1, 1, 2, 1, 7, 1, 0, 0, 0);
        step(1, 3, 1, 4, 1, 10, 1, 0, 0, 0);
        step(1, 1, 1, 7, 1, 11, 1, 0, 0, 0);
        chk("t2_sel_b", {30'd0, ex_fwd_b_sel}, 32'd1);

        // lw x8 ; add x9,x8,x8 -> one bubble then MEM/WB forward on both
        step(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        step(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
        chk("t3_stall", {31'd0, last_stall}, 32'd1);
        chk("t3_bubble_a", {30'd0, ex_fwd_a_sel}, 32'd0);
        step(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
        chk("t3_stall_once", {31'd0, last_stall}, 32'd0);
        chk("t3_sel_a", {30'd0, ex_fwd_a_sel}, 32'd1);
        chk("t3_sel_b", {30'd0, ex_fwd_b_sel}, 32'd1);

        // x0 never forwards; unused rs2 never forwards or stalls
        step(1, 1, 1, 2, 1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 12, 1, 0, 0, 0);
        chk("t4_x0_stall", {31'd0, last_stall}, 32'd0);
        chk("t4_x0_sel_a", {30'd0, ex_fwd_a_sel}, 32'd0);
        step(1, 1, 1, 2, 1, 3, 1, 1, 0, 0);
        step(1, 4, 1, 3, 0, 13, 1, 0, 0, 0);
        chk("t4_use_stall", {31'd0, last_stall}, 32'd0);
        chk("t4_use_sel_b", {30'd0, ex_fwd_b_sel}, 32'd0);

        // load-use killed by flush
        step(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 1);
        chk("t5_flush_stall", {31'd0, last_stall}, 32'd0);
        chk("t5_flush_sel", {30'd0, ex_fwd_a_sel}, 32'd0);

        // load-use under a three-cycle hold
        step(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 8, 1, 0, 0, 9, 1, 0, 1, 0);
            chk("t6_hold_stall", {31'd0, last_stall}, 32'd1);
        end
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
        chk("t6_stall_release", {31'd0, last_stall}, 32'd1);
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
        chk("t6_sel_a", {30'd0, ex_fwd_a_sel}, 32'd1);

        // asynchronous reset in the middle of a stall
        step(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
        #1;
        chk("t7_pre_stall", {31'd0, stall_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("t7_rst_sel_a", {30'd0, ex_fwd_a_sel}, 32'd0);
        chk("t7_rst_sel_b", {30'd0, ex_fwd_b_sel}, 32'd0);
        m_reset();
        #1;
        rst_n = 1'b1;
        step(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
        chk("t7_after_stall", {31'd0, last_stall}, 32'd1);
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);

        // randomized traffic over a small register window for frequent hits
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
